// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_pkg
// Purpose  : Shared definitions for the LC-3 control unit: microsequencer
//            state encoding, opcodes, ALU operation codes, datapath mux
//            select codes, the bundled control-word type and NZP helper.
// Revision : 1.0  initial release
// ============================================================================
package lc3_pkg;

   typedef enum logic [4:0] {
      S_FETCH1 = 5'd0,
      S_FETCH2 = 5'd1,
      S_FETCH3 = 5'd2,
      S_DECODE = 5'd3,
      S_ALU    = 5'd4,
      S_BR     = 5'd5,
      S_JMP    = 5'd6,
      S_LINK   = 5'd7,
      S_JSR    = 5'd8,
      S_ADDR   = 5'd9,
      S_RD     = 5'd10,
      S_WB     = 5'd11,
      S_SDATA  = 5'd12,
      S_WR     = 5'd13,
      S_LEA    = 5'd14,
      S_TVEC   = 5'd15,
      S_TJMP   = 5'd16,
      S_HALT   = 5'd17
   } state_t;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] ALUK_AND   = 2'b00;
   localparam logic [1:0] ALUK_NOT   = 2'b01;
   localparam logic [1:0] ALUK_ADD   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   localparam logic       A1M_SR1     = 1'b0;
   localparam logic       A1M_PC      = 1'b1;
   localparam logic [1:0] A2M_SEXT11  = 2'd0;
   localparam logic [1:0] A2M_SEXT9   = 2'd1;
   localparam logic [1:0] A2M_SEXT6   = 2'd2;
   localparam logic [1:0] A2M_ZERO    = 2'd3;
   localparam logic [1:0] PCMUX_BUS   = 2'd0;
   localparam logic [1:0] PCMUX_ADDER = 2'd1;
   localparam logic [1:0] PCMUX_INC   = 2'd2;
   localparam logic       MARMUX_ZEXT8 = 1'b0;
   localparam logic       MARMUX_ADDER = 1'b1;

   // One control word per cycle; ld_cc stays internal to the control unit.
   typedef struct packed {
      logic       ld_ir;
      logic       ld_reg;
      logic       ld_pc;
      logic [2:0] dr;
      logic [2:0] sr1;
      logic [2:0] sr2;
      logic [1:0] aluk;
      logic       gate_alu;
      logic       gate_pc;
      logic       gate_marmux;
      logic       gate_mdr;
      logic       a1m_sel;
      logic [1:0] a2m_sel;
      logic [1:0] pcmux_sel;
      logic       marmux_sel;
      logic       ld_mar;
      logic       ld_mdr;
      logic       mio_en;
      logic       r_w;
      logic       halted;
      logic       ld_cc;
   } ctl_t;

   // Condition code for a bus value: {N, Z, P}, exactly one bit set.
   function automatic logic [2:0] nzp_of(input logic [15:0] value);
      if (value[15])
         return 3'b100;
      else if (value == 16'h0000)
         return 3'b010;
      else
         return 3'b001;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_nzp.sv
`default_nettype none
// ============================================================================
// Module   : lc3_nzp
// Purpose  : NZP condition-code register and branch-enable latch.
// Ports    : clk, rst_n         - clock, async active-low reset
//            ld_cc, bus         - load NZP from the classification of bus
//            ir_nzp, ld_ben     - branch mask from IR; latch BEN when ld_ben
//            nzp, ben           - current condition codes and branch enable
// Revision : 1.0  initial release
// ============================================================================
module lc3_nzp
   import lc3_pkg::*;
#(
   parameter logic [2:0] RESET_NZP = 3'b010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_cc,
   input  logic [15:0] bus,
   input  logic [2:0]  ir_nzp,
   input  logic        ld_ben,
   output logic [2:0]  nzp,
   output logic        ben
);

   logic [2:0] nzp_q;
   logic       ben_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nzp_q <= RESET_NZP;
         ben_q <= 1'b0;
      end else begin
         if (ld_cc)
            nzp_q <= nzp_of(bus);
         // BEN uses the NZP value present before this edge, so a branch
         // never observes a condition-code update from its own cycle.
         if (ld_ben)
            ben_q <= |(ir_nzp & nzp_q);
      end
   end

   assign nzp = nzp_q;
   assign ben = ben_q;

endmodule
`default_nettype wire

// File: rtl/lc3_control.sv
`default_nettype none
// ============================================================================
// Module   : lc3_control
// Purpose  : LC-3 microsequencer. Moore FSM issuing datapath load, gate and
//            mux-select strobes one state per cycle, running the MAR/MDR
//            memory handshake, and owning the NZP condition codes.
// Ports    : clk, rst_n, ir, bus, mem_ready               - inputs
//            ld_ir/ld_reg/ld_pc, dr/sr1/sr2, aluk,
//            gate_alu/gate_pc/gate_marmux/gate_mdr,
//            a1m_sel, a2m_sel, pcmux_sel, marmux_sel,
//            ld_mar, ld_mdr, mio_en, r_w, halted          - datapath controls
// Revision : 1.0  initial release
// ============================================================================
module lc3_control
   import lc3_pkg::*;
#(
   parameter logic [2:0] RESET_NZP = 3'b010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ir,
   input  logic [15:0] bus,
   input  logic        mem_ready,
   output logic        ld_ir,
   output logic        ld_reg,
   output logic        ld_pc,
   output logic [2:0]  dr,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [1:0]  aluk,
   output logic        gate_alu,
   output logic        gate_pc,
   output logic        gate_marmux,
   output logic        gate_mdr,
   output logic        a1m_sel,
   output logic [1:0]  a2m_sel,
   output logic [1:0]  pcmux_sel,
   output logic        marmux_sel,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        mio_en,
   output logic        r_w,
   output logic        halted
);

   state_t     state_q, state_d;
   ctl_t       ctl, ctl_out;
   logic [3:0] opcode;
   logic       ben;
   logic [2:0] nzp;
   logic       unused_bits;

   assign opcode = ir[15:12];

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_FETCH1;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: if (mem_ready) state_d = S_FETCH3;
         S_FETCH3: state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_AND, OP_NOT: state_d = S_ALU;
               OP_BR:                  state_d = S_BR;
               OP_JMP:                 state_d = S_JMP;
               OP_JSR, OP_TRAP:        state_d = S_LINK;
               OP_LD, OP_LDR,
               OP_ST, OP_STR:          state_d = S_ADDR;
               OP_LEA:                 state_d = S_LEA;
               default:                state_d = S_HALT;
            endcase
         end
         S_LINK:   state_d = (opcode == OP_TRAP) ? S_TVEC : S_JSR;
         S_ADDR:   state_d = (opcode == OP_ST || opcode == OP_STR) ? S_SDATA : S_RD;
         // RD is shared by loads and TRAP; the opcode picks the follow-on.
         S_RD:     if (mem_ready) state_d = (opcode == OP_TRAP) ? S_TJMP : S_WB;
         S_TVEC:   state_d = S_RD;
         S_SDATA:  state_d = S_WR;
         S_WR:     if (mem_ready) state_d = S_FETCH1;
         S_HALT:   state_d = S_HALT;
         S_ALU, S_BR, S_JMP, S_JSR,
         S_WB, S_LEA, S_TJMP:
                   state_d = S_FETCH1;
         default:  state_d = S_FETCH1;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      ctl = '0;
      case (state_q)
         S_FETCH1: begin
            ctl.gate_pc   = 1'b1;
            ctl.ld_mar    = 1'b1;
            ctl.ld_pc     = 1'b1;
            ctl.pcmux_sel = PCMUX_INC;
         end
         S_FETCH2, S_RD: begin
            ctl.mio_en = 1'b1;
            ctl.ld_mdr = mem_ready;
         end
         S_FETCH3: begin
            ctl.gate_mdr = 1'b1;
            ctl.ld_ir    = 1'b1;
         end
         S_ALU: begin
            ctl.gate_alu = 1'b1;
            ctl.ld_reg   = 1'b1;
            ctl.ld_cc    = 1'b1;
            ctl.dr       = ir[11:9];
            ctl.sr1      = ir[8:6];
            ctl.sr2      = ir[2:0];
            case (opcode)
               OP_ADD:  ctl.aluk = ALUK_ADD;
               OP_AND:  ctl.aluk = ALUK_AND;
               default: ctl.aluk = ALUK_NOT;
            endcase
         end
         S_BR: begin
            if (ben) begin
               ctl.ld_pc     = 1'b1;
               ctl.pcmux_sel = PCMUX_ADDER;
               ctl.a1m_sel   = A1M_PC;
               ctl.a2m_sel   = A2M_SEXT9;
            end
         end
         S_JMP: begin
            ctl.ld_pc     = 1'b1;
            ctl.pcmux_sel = PCMUX_ADDER;
            ctl.a1m_sel   = A1M_SR1;
            ctl.a2m_sel   = A2M_ZERO;
            ctl.sr1       = ir[8:6];
         end
         S_LINK: begin
            ctl.gate_pc = 1'b1;
            ctl.ld_reg  = 1'b1;
            ctl.dr      = 3'd7;
         end
         S_JSR: begin
            ctl.ld_pc     = 1'b1;
            ctl.pcmux_sel = PCMUX_ADDER;
            if (ir[11]) begin
               ctl.a1m_sel = A1M_PC;
               ctl.a2m_sel = A2M_SEXT11;
            end else begin
               ctl.a1m_sel = A1M_SR1;
               ctl.a2m_sel = A2M_ZERO;
               ctl.sr1     = ir[8:6];
            end
         end
         S_ADDR: begin
            ctl.ld_mar      = 1'b1;
            ctl.gate_marmux = 1'b1;
            ctl.marmux_sel  = MARMUX_ADDER;
            if (opcode == OP_LD || opcode == OP_ST) begin
               ctl.a1m_sel = A1M_PC;
               ctl.a2m_sel = A2M_SEXT9;
            end else begin
               ctl.a1m_sel = A1M_SR1;
               ctl.a2m_sel = A2M_SEXT6;
               ctl.sr1     = ir[8:6];
            end
         end
         S_WB: begin
            ctl.gate_mdr = 1'b1;
            ctl.ld_reg   = 1'b1;
            ctl.ld_cc    = 1'b1;
            ctl.dr       = ir[11:9];
         end
         S_SDATA: begin
            ctl.sr1      = ir[11:9];
            ctl.aluk     = ALUK_PASSA;
            ctl.gate_alu = 1'b1;
            ctl.ld_mdr   = 1'b1;
         end
         S_WR: begin
            ctl.mio_en = 1'b1;
            ctl.r_w    = 1'b1;
         end
         S_LEA: begin
            ctl.gate_marmux = 1'b1;
            ctl.marmux_sel  = MARMUX_ADDER;
            ctl.a1m_sel     = A1M_PC;
            ctl.a2m_sel     = A2M_SEXT9;
            ctl.ld_reg      = 1'b1;
            ctl.dr          = ir[11:9];
         end
         S_TVEC: begin
            ctl.ld_mar      = 1'b1;
            ctl.gate_marmux = 1'b1;
            ctl.marmux_sel  = MARMUX_ZEXT8;
         end
         S_TJMP: begin
            ctl.gate_mdr  = 1'b1;
            ctl.ld_pc     = 1'b1;
            ctl.pcmux_sel = PCMUX_BUS;
         end
         S_HALT: ctl.halted = 1'b1;
         default: ctl = '0;
      endcase
   end

   // The state register already sits in FETCH1 during reset; masking with
   // rst_n keeps every strobe (including mio_en) low until release.
   assign ctl_out = rst_n ? ctl : '0;

   assign ld_ir       = ctl_out.ld_ir;
   assign ld_reg      = ctl_out.ld_reg;
   assign ld_pc       = ctl_out.ld_pc;
   assign dr          = ctl_out.dr;
   assign sr1         = ctl_out.sr1;
   assign sr2         = ctl_out.sr2;
   assign aluk        = ctl_out.aluk;
   assign gate_alu    = ctl_out.gate_alu;
   assign gate_pc     = ctl_out.gate_pc;
   assign gate_marmux = ctl_out.gate_marmux;
   assign gate_mdr    = ctl_out.gate_mdr;
   assign a1m_sel     = ctl_out.a1m_sel;
   assign a2m_sel     = ctl_out.a2m_sel;
   assign pcmux_sel   = ctl_out.pcmux_sel;
   assign marmux_sel  = ctl_out.marmux_sel;
   assign ld_mar      = ctl_out.ld_mar;
   assign ld_mdr      = ctl_out.ld_mdr;
   assign mio_en      = ctl_out.mio_en;
   assign r_w         = ctl_out.r_w;
   assign halted      = ctl_out.halted;

   // ------------------------------------------------------ condition codes
   lc3_nzp #(
      .RESET_NZP (RESET_NZP)
   ) u_nzp (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld_cc  (ctl_out.ld_cc),
      .bus    (bus),
      .ir_nzp (ir[11:9]),
      .ld_ben (state_q == S_DECODE),
      .nzp    (nzp),
      .ben    (ben)
   );

   // imm5 and the raw NZP value are not needed by the sequencer itself.
   assign unused_bits = ^{ir[5:3], nzp};

endmodule
`default_nettype wire
